// File: rtl/io_bridge.sv
// io_bridge: data-bus decoder steering accesses to DRAM or to the
// LED/switch/seven-segment/timer peripherals. Timer built only with IO_TIMER_EN.
module io_bridge #(
    parameter int SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

    localparam logic [11:0] OFF_DIG  = 12'h000;
    localparam logic [11:0] OFF_TCNT = 12'h020;
    localparam logic [11:0] OFF_TDIV = 12'h024;
    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;

    logic        hit;
    logic [11:0] offset;
    logic        we_dig;
    logic        we_led;
    logic [31:0] dig_r;
    logic [23:0] led_r;
    logic [23:0] sw_s1;
    logic [23:0] sw_s2;
    logic [SCW-1:0] scan_cnt;
    logic [2:0]  idx;
    logic [3:0]  nib;
    logic [31:0] tcnt_rd;
    logic [31:0] tdiv_rd;

    assign hit        = (Bus_addr[31:12] == 20'hFFFFF);
    assign offset     = Bus_addr[11:0];
    assign dram_addr  = Bus_addr[15:2];
    assign dram_wdata = Bus_wdata;
    assign dram_wen   = Bus_wen & ~hit;
    assign we_dig     = Bus_wen & hit & (offset == OFF_DIG);
    assign we_led     = Bus_wen & hit & (offset == OFF_LED);
    assign led        = led_r;
    assign nib        = dig_r[{idx, 2'b00} +: 4];

    // Active-low {A..G,DP} glyph for one hex nibble, DP off.
    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    // Writable display and LED registers.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            dig_r <= '0;
            led_r <= '0;
        end else begin
            if (we_dig) dig_r <= Bus_wdata;
            if (we_led) led_r <= Bus_wdata[23:0];
        end
    end

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    // Scan prescaler and digit index; index advances on terminal count.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Registered digit enable and segment drive for the current index.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            dig_en  <= 8'hFE;
            dig_seg <= 8'h03;
        end else begin
            dig_en  <= ~(8'b1 << idx);
            dig_seg <= hex_seg(nib);
        end
    end

`ifdef IO_TIMER_EN
    logic        we_tcnt;
    logic        we_tdiv;
    logic        tick;
    logic [31:0] tcnt;
    logic [31:0] tdiv;
    logic [31:0] tpre;

    assign we_tcnt = Bus_wen & hit & (offset == OFF_TCNT);
    assign we_tdiv = Bus_wen & hit & (offset == OFF_TDIV);
    assign tick    = (tpre == tdiv);
    assign tcnt_rd = tcnt;
    assign tdiv_rd = tdiv;

    // Timer: a TCNT write beats a same-edge tick; TDIV write restarts prescale.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            tcnt <= '0;
            tdiv <= '0;
            tpre <= '0;
        end else begin
            if (we_tdiv) begin
                tdiv <= Bus_wdata;
                tpre <= '0;
            end else if (tick) begin
                tpre <= '0;
            end else begin
                tpre <= tpre + 32'd1;
            end
            if (we_tcnt) tcnt <= Bus_wdata;
            else if (tick) tcnt <= tcnt + 32'd1;
        end
    end
`else
    assign tcnt_rd = '0;
    assign tdiv_rd = '0;
`endif

    // Zero-latency read mux back to the core.
    always_comb begin
        Bus_rdata = dram_rdata;
        if (hit) begin
            case (offset)
                OFF_DIG:  Bus_rdata = dig_r;
                OFF_TCNT: Bus_rdata = tcnt_rd;
                OFF_TDIV: Bus_rdata = tdiv_rd;
                OFF_LED:  Bus_rdata = {8'h00, led_r};
                OFF_SW:   Bus_rdata = {8'h00, sw_s2};
                default:  Bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed plus randomized checks of io_bridge against
// an edge-count based reference model of the bus, display and timer.
module tb_io_bridge;

    localparam logic [31:0] A_DIG  = 32'hFFFFF000;
    localparam logic [31:0] A_TCNT = 32'hFFFFF020;
    localparam logic [31:0] A_TDIV = 32'hFFFFF024;
    localparam logic [31:0] A_LED  = 32'hFFFFF060;
    localparam logic [31:0] A_SW   = 32'hFFFFF070;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    int n_chk = 0;
    int n_fail = 0;
    int ec = 0;

    io_bridge #(.SCAN_DIV(4)) dut (
        .cpu_clk   (clk),
        .cpu_rst   (rst),
        .Bus_addr  (Bus_addr),
        .Bus_wen   (Bus_wen),
        .Bus_wdata (Bus_wdata),
        .Bus_rdata (Bus_rdata),
        .dram_addr (dram_addr),
        .dram_wen  (dram_wen),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .sw        (sw),
        .led       (led),
        .dig_en    (dig_en),
        .dig_seg   (dig_seg)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge.
    always @(posedge clk) begin
        if (rst) ec <= 0;
        else ec <= ec + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Bus_addr = a;
        Bus_wdata = d;
        Bus_wen = 1'b1;
        step();
        Bus_wen = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Bus_addr = a;
        Bus_wen = 1'b0;
        #1;
        d = Bus_rdata;
    endtask

    // Glyph from an active-high abcdefg table, converted to the pin format.
    function automatic logic [7:0] glyph(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return {~t[v], 1'b1};
    endfunction

    task automatic scan_check(input logic [31:0] dv, input int cycles);
        int k;
        int d;
        logic [7:0] e_en;
        wr(A_DIG, dv);
        step();
        step();
        for (int i = 0; i < cycles; i++) begin
            k = ec;
            d = ((k - 1) / 4) % 8;
            e_en = ~(8'b1 << d);
            chk("scan_en", {24'h0, dig_en}, {24'h0, e_en});
            chk("scan_seg", {24'h0, dig_seg}, {24'h0, glyph(dv[4*d +: 4])});
            step();
        end
    endtask

    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] d;
    logic [23:0] led_m;
`ifdef IO_TIMER_EN
    int e0;
    int e1;
    logic [31:0] v;

    // TCNT after edge n: value written at edge e1 plus ticks strictly after
    // e1, ticks landing every (div+1) edges after the TDIV write at e0.
    function automatic logic [31:0] tmodel(input int n, input int w,
                                           input logic [31:0] val,
                                           input int p);
        return val + 32'((n - e0) / p - (w - e0) / p);
    endfunction
`endif

    initial begin
        rst = 1'b1;
        Bus_addr = 32'h0;
        Bus_wen = 1'b0;
        Bus_wdata = 32'h0;
        dram_rdata = 32'h0;
        sw = 24'h0;
        led_m = 24'h0;
        step();
        step();
        chk("rst_led", {8'h0, led}, 32'h0);
        chk("rst_dig_en", {24'h0, dig_en}, 32'hFE);
        chk("rst_dig_seg", {24'h0, dig_seg}, 32'h03);
        chk("rst_dram_wen", {31'h0, dram_wen}, 32'h0);
        rst = 1'b0;
        rd(A_DIG, r);
        chk("rst_dig_rd", r, 32'h0);

        wr(A_LED, 32'h00ABCDEF);
        led_m = 24'hABCDEF;
        chk("led_out", {8'h0, led}, 32'h00ABCDEF);
        rd(A_LED, r);
        chk("led_rd", r, 32'h00ABCDEF);
        Bus_addr = A_LED;
        Bus_wen = 1'b1;
        #1;
        chk("led_no_dram_wen", {31'h0, dram_wen}, 32'h0);
        Bus_wen = 1'b0;

        Bus_addr = 32'h00001234;
        Bus_wdata = 32'h0BADF00D;
        Bus_wen = 1'b1;
        dram_rdata = 32'hDEADBEEF;
        #1;
        chk("dram_wen", {31'h0, dram_wen}, 32'h1);
        chk("dram_addr", {18'h0, dram_addr}, 32'h48D);
        chk("dram_wdata", dram_wdata, 32'h0BADF00D);
        chk("dram_rdata", Bus_rdata, 32'hDEADBEEF);
        Bus_wen = 1'b0;
        step();

        scan_check(32'h76543210, 40);
        scan_check($urandom, 36);

        rd(32'hFFFFF100, r);
        chk("unmapped_rd", r, 32'h0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    d = $urandom;
                    wr(A_LED, d);
                    led_m = d[23:0];
                    chk("rnd_led", {8'h0, led}, {8'h0, led_m});
                    rd(A_LED, r);
                    chk("rnd_led_rd", r, {8'h0, led_m});
                end
                1: begin
                    a = $urandom;
                    a[31:30] = 2'b00;
                    d = $urandom;
                    Bus_addr = a;
                    Bus_wdata = d;
                    Bus_wen = 1'($urandom);
                    dram_rdata = $urandom;
                    #1;
                    chk("rnd_dram_wen", {31'h0, dram_wen}, {31'h0, Bus_wen});
                    chk("rnd_dram_addr", {18'h0, dram_addr}, {18'h0, a[15:2]});
                    chk("rnd_dram_wd", dram_wdata, d);
                    chk("rnd_dram_rd", Bus_rdata, dram_rdata);
                    step();
                    Bus_wen = 1'b0;
                end
                2: begin
                    a = 32'hFFFFF100 + 32'($urandom_range(0, 63) * 4);
                    wr(a, $urandom);
                    rd(a, r);
                    chk("rnd_unmap_rd", r, 32'h0);
                    rd(A_LED, r);
                    chk("rnd_unmap_led", r, {8'h0, led_m});
                end
                default: begin
                    sw = 24'($urandom);
                    step();
                    step();
                    rd(A_SW, r);
                    chk("rnd_sw", r, {8'h0, sw});
                end
            endcase
        end

        sw = 24'h123456;
        step();
        step();
        rd(A_SW, r);
        chk("sw_sync", r, 32'h00123456);

`ifdef IO_TIMER_EN
        wr(A_TDIV, 32'd2);
        e0 = ec;
        wr(A_TCNT, 32'd0);
        e1 = ec;
        v = 32'd0;
        for (int i = 0; i < 10; i++) begin
            rd(A_TCNT, r);
            chk("tmr_div2", r, tmodel(ec, e1, v, 3));
            step();
        end
        wr(A_TCNT, 32'hFFFFFFFF);
        e1 = ec;
        v = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            rd(A_TCNT, r);
            chk("tmr_wrap", r, tmodel(ec, e1, v, 3));
            step();
        end
        while (((ec + 1 - e0) % 3) != 0) step();
        wr(A_TCNT, 32'd5);
        e1 = ec;
        v = 32'd5;
        rd(A_TCNT, r);
        chk("tmr_wr_prio", r, 32'd5);
        for (int i = 0; i < 7; i++) begin
            step();
            rd(A_TCNT, r);
            chk("tmr_after_prio", r, tmodel(ec, e1, v, 3));
        end
        rd(A_TDIV, r);
        chk("tdiv_rd", r, 32'd2);
`else
        wr(A_TCNT, $urandom);
        wr(A_TDIV, $urandom);
        rd(A_TCNT, r);
        chk("no_tmr_tcnt", r, 32'h0);
        rd(A_TDIV, r);
        chk("no_tmr_tdiv", r, 32'h0);
`endif

        Bus_addr = A_LED;
        Bus_wdata = 32'h00FFFFFF;
        Bus_wen = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        Bus_wen = 1'b0;
        chk("rst_mid_led", {8'h0, led}, 32'h0);
        chk("rst_mid_en", {24'h0, dig_en}, 32'hFE);
        rd(A_LED, r);
        chk("rst_mid_led_rd", r, 32'h0);
        rd(A_SW, r);
        chk("rst_mid_sw", r, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
